f1_start_sequencer: RTL and testbench
=====================================

# f1_start_sequencer

Control stage upstream of the F1 start-light FSM. It issues single-cycle `en` advance pulses at a fixed interval to light the eight lamps one by one. It then holds all lamps lit for a pseudo-random time and issues the final `en` that turns them all off ("lights out"). After lights out it measures the driver's reaction time in clock cycles, and it detects jump starts.

## Interface
- `TICK_N`, default 16'd48: number of cycles between successive lamp steps; must be ≥2.
- `TICK_WIDTH`, default 16: width of the step/hold counter; must be ≥11.
- `RT_WIDTH`, default 16: width of the reaction-time counter.

Ports:
- `clk`  in  1: single clock, all state on rising edge.
- `rst`  in  1: synchronous, active-high reset; shared with the light FSM.
- `trigger`  in  1: request to start a sequence; sampled in IDLE only.
- `lights`  in  8: current lamp vector from the light FSM (0x00, 0x01, 0x03 … 0xFF).
- `btn`  in  1: driver button, already synchronised and debounced.
- `en`  out  1: single-cycle advance pulse to the light FSM.
- `lights_out`  out  1: single-cycle pulse coincident with the `en` that darkens all lamps.
- `react_time`  out  RT_WIDTH: last measured reaction time in cycles.
- `react_valid`  out  1: single-cycle pulse when `react_time` updates.
- `jump_start`  out  1: sticky flag, set on early button press, cleared on next accepted trigger.
- `busy`  out  1: high in every state except IDLE.

## Operation
- LFSR: 7-bit Fibonacci LFSR, x^7+x^6+1. Reset seed is 7'h01. It advances every cycle, including in IDLE, and never reaches 0.
- States:
  - **IDLE**: `trigger`=1 and `lights`==0 → STEP. The step counter is loaded with TICK_N-1 and the step index with 0. `jump_start` is cleared. A trigger with `lights`≠0 is ignored.
  - **STEP**: the counter decrements each cycle. At counter==0, `en`=1, the counter reloads TICK_N-1 and the step index increments. The 8th `en` → HOLD. In that cycle, L = current LFSR value is captured and the counter is loaded with H-1, where H = TICK_N + 8·L.
  - **HOLD**: the counter decrements. At counter==0, `en`=1 and `lights_out`=1, the reaction counter is cleared → REACT.
  - **REACT**: the reaction counter increments each cycle and saturates at all-ones. On `btn`=1, `react_time` ← counter+1 and `react_valid`=1 → IDLE. There is no timeout.
  - **ABORT**: entered when `btn`=1 in any STEP or HOLD cycle. `jump_start` ← 1, and no `lights_out` is issued.
    - `en` = (`lights`≠0) and no `en` in the previous cycle, so the FSM runs forward to S0 with alternating-cycle pulses.
    - Exit → IDLE when `lights`==0 and no `en` was issued in the previous cycle.
- Priority:
  - `btn` in the final HOLD cycle counts as a jump start, not a reaction.
  - `btn` in STEP on an `en` cycle: the `en` is still issued that cycle, then the block enters ABORT.
  - `trigger` outside IDLE is ignored.
- Outputs `en`, `lights_out`, `react_valid` and `busy` are decoded from registered state/counters (Moore). `react_time` and `jump_start` are registers.

## Timing
- Reset: state IDLE, LFSR 7'h01, all counters 0. `en`, `lights_out`, `react_valid`, `busy`, `jump_start` are 0, and `react_time` is 0.
  - Reset mid-sequence → IDLE on the next edge with all outputs 0. The light FSM resets to S0 in the same cycle.
- Trigger accepted at cycle t:
  - `busy`=1 from t+1.
  - `en` at t+k·TICK_N for k=1..8.
  - `lights` reads 0xFF from t+8·TICK_N+1.
  - `lights_out` and the 9th `en` at t+8·TICK_N+H, with H ∈ [TICK_N+8, TICK_N+1016].
- Reaction: `lights_out` at cycle u, `btn` first high at cycle u+k (k≥1). Then `react_valid`=1 and `react_time`=k at cycle u+k+1, and `busy`=0 from u+k+1.
- `react_time` holds its value until the next `react_valid`. It is not cleared by trigger.
- `en` is never high in two consecutive cycles.

## Test plan
- **Reset behaviour**: reset, then hold `trigger`=0 for 20 cycles → `en`, `busy`, `lights_out`, `react_valid`, `jump_start` all 0 and `react_time`=0.
- **Full sequence**: TICK_N=4, light FSM attached, trigger at cycle 10.
  - `en` at 14, 18, …, 42, and `lights`=0xFF from 43.
  - `lights_out` at 42+H, where H = 4+8·L and L is the reference-model LFSR value at cycle 42.
  - `lights` returns to 0x00 one cycle after `lights_out`.
- **Reaction measurement**: `btn` asserted 37 cycles after `lights_out` → `react_valid` pulse one cycle later with `react_time`=37, then `busy`=0.
- **Jump start in HOLD**: `btn` asserted 3 cycles after the 8th `en` → `jump_start`=1 and no `lights_out`.
  - Alternating `en` pulses follow until `lights`=0x00, then IDLE.
  - The next trigger clears `jump_start`.
- **Jump start mid-STEP**: `btn` asserted after the 3rd `en` (`lights`=0x07) → 6 further `en` pulses on alternate cycles, `lights` reaches 0x00, and no `react_valid`.
- **Ignored inputs**:
  - `trigger` pulses during STEP, HOLD and REACT have no effect on `en` timing.
  - Reset asserted during HOLD → all outputs 0 next cycle, `lights`=0x00, and a fresh trigger restarts cleanly.

Source files
------------

// File: rtl/f1_start_sequencer.sv
// f1_start_sequencer
//    Drives the F1 start-light FSM: lights the eight lamps one step every
//    TICK_N cycles, holds all lamps for a pseudo-random time, then issues
//    "lights out" and measures the driver's reaction time in cycles.
//    A button press before lights out is flagged as a jump start and the
//    light FSM is run forward to its dark state.
//
// Ports
//    clk_i          clock, all state on rising edge
//    rst_i          synchronous active-high reset
//    trigger_i      start request, honoured in IDLE with all lamps dark
//    lights_i[7:0]  lamp vector fed back from the light FSM
//    btn_i          driver button (synchronised, debounced)
//    en_o           single-cycle advance pulse to the light FSM
//    lights_out_o   pulse coincident with the en that darkens all lamps
//    react_time_o   last measured reaction time in cycles
//    react_valid_o  single-cycle pulse when react_time_o updates
//    jump_start_o   sticky early-press flag, cleared by the next start
//    busy_o         high whenever not IDLE
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for trigger with lamps dark
// STEP   | lighting lamps, one en every TICK_N cycles
// HOLD   | all lamps lit, random hold timer running
// REACT  | lamps dark, counting cycles until the button is pressed
// ABORT  | jump start: pulse en on alternate cycles until lamps are dark

module f1_start_sequencer #(
   parameter logic [15:0] TICK_N     = 16'd48,
   parameter int          TICK_WIDTH = 16,
   parameter int          RT_WIDTH   = 16
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                trigger_i,
   input  logic [7:0]          lights_i,
   input  logic                btn_i,
   output logic                en_o,
   output logic                lights_out_o,
   output logic [RT_WIDTH-1:0] react_time_o,
   output logic                react_valid_o,
   output logic                jump_start_o,
   output logic                busy_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_STEP,
      S_HOLD,
      S_REACT,
      S_ABORT
   } state_e;

   localparam logic [TICK_WIDTH-1:0] TICK_ONE    = TICK_WIDTH'(1);
   localparam logic [TICK_WIDTH-1:0] TICK_RELOAD = TICK_WIDTH'(TICK_N) - TICK_ONE;
   localparam logic [RT_WIDTH-1:0]   RT_ONE      = RT_WIDTH'(1);
   localparam logic [RT_WIDTH-1:0]   RT_MAX      = '1;

   state_e                state_q, state_d;
   logic [6:0]            lfsr_q, lfsr_d;
   logic [TICK_WIDTH-1:0] cnt_q, cnt_d;
   logic [2:0]            idx_q, idx_d;
   logic [RT_WIDTH-1:0]   rcnt_q, rcnt_d;
   logic [RT_WIDTH-1:0]   react_time_q, react_time_d;
   logic                  react_valid_q, react_valid_d;
   logic                  jump_q, jump_d;
   logic                  en_q;
   logic [TICK_WIDTH-1:0] hold_load;

   // x^7 + x^6 + 1: feedback from the two top taps; nonzero seed keeps it off 0
   assign lfsr_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};

   // H - 1 with H = TICK_N + 8*L
   assign hold_load = TICK_WIDTH'(TICK_N) + TICK_WIDTH'({lfsr_q, 3'b000}) - TICK_ONE;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= S_IDLE;
         lfsr_q        <= 7'h01;
         cnt_q         <= '0;
         idx_q         <= '0;
         rcnt_q        <= '0;
         react_time_q  <= '0;
         react_valid_q <= 1'b0;
         jump_q        <= 1'b0;
         en_q          <= 1'b0;
      end else begin
         state_q       <= state_d;
         lfsr_q        <= lfsr_d;
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         rcnt_q        <= rcnt_d;
         react_time_q  <= react_time_d;
         react_valid_q <= react_valid_d;
         jump_q        <= jump_d;
         en_q          <= en_o;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      idx_d         = idx_q;
      rcnt_d        = rcnt_q;
      react_time_d  = react_time_q;
      react_valid_d = 1'b0;
      jump_d        = jump_q;
      en_o          = 1'b0;
      lights_out_o  = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (trigger_i && (lights_i == 8'h00)) begin
               state_d = S_STEP;
               cnt_d   = TICK_RELOAD;
               idx_d   = 3'd0;
               jump_d  = 1'b0;
            end
         end

         S_STEP: begin
            en_o = (cnt_q == '0);
            if (cnt_q == '0) begin
               cnt_d = TICK_RELOAD;
               idx_d = idx_q + 3'd1;
               if (idx_q == 3'd7) begin
                  state_d = S_HOLD;
                  cnt_d   = hold_load;
               end
            end else begin
               cnt_d = cnt_q - TICK_ONE;
            end
            // the en above is Moore and still goes out; the press wins the transition
            if (btn_i) begin
               state_d = S_ABORT;
               jump_d  = 1'b1;
            end
         end

         S_HOLD: begin
            en_o         = (cnt_q == '0);
            lights_out_o = (cnt_q == '0);
            if (cnt_q == '0) begin
               state_d = S_REACT;
               rcnt_d  = '0;
            end else begin
               cnt_d = cnt_q - TICK_ONE;
            end
            if (btn_i) begin
               state_d = S_ABORT;
               jump_d  = 1'b1;
            end
         end

         S_REACT: begin
            if (rcnt_q != RT_MAX) begin
               rcnt_d = rcnt_q + RT_ONE;
            end
            if (btn_i) begin
               react_time_d  = (rcnt_q == RT_MAX) ? RT_MAX : rcnt_q + RT_ONE;
               react_valid_d = 1'b1;
               state_d       = S_IDLE;
            end
         end

         S_ABORT: begin
            // en_q gap lets the light FSM register each step before the next pulse
            en_o = (lights_i != 8'h00) && !en_q;
            if ((lights_i == 8'h00) && !en_q) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign react_time_o  = react_time_q;
   assign react_valid_o = react_valid_q;
   assign jump_start_o  = jump_q;
   assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_f1_start_sequencer.sv
module tb_f1_start_sequencer;

   localparam int T = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        trigger;
   logic        btn;
   logic [7:0]  lights;
   logic        en;
   logic        lights_out;
   logic [15:0] react_time;
   logic        react_valid;
   logic        jump_start;
   logic        busy;

   int          errors = 0;
   int          checks = 0;
   int          n_rst;
   logic [6:0]  seq [127];
   logic [15:0] last_rt;

   always #5 clk = ~clk;

   f1_start_sequencer #(
      .TICK_N     (16'd4),
      .TICK_WIDTH (16),
      .RT_WIDTH   (16)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .trigger_i     (trigger),
      .lights_i      (lights),
      .btn_i         (btn),
      .en_o          (en),
      .lights_out_o  (lights_out),
      .react_time_o  (react_time),
      .react_valid_o (react_valid),
      .jump_start_o  (jump_start),
      .busy_o        (busy)
   );

   // attached light FSM: each en lights one more lamp, en at 0xFF goes dark
   always @(posedge clk) begin
      if (rst)               lights <= 8'h00;
      else if (en)           lights <= (lights == 8'hFF) ? 8'h00 : {lights[6:0], 1'b1};
   end

   // cycles since the last reset edge; LFSR value in a cycle is seq[n_rst % 127]
   always @(posedge clk) begin
      if (rst) n_rst <= 0;
      else     n_rst <= n_rst + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic outs(input string ph, input bit e_en, input bit e_lo, input bit e_rv, input bit e_busy);
      chk({ph, ".en"},          en,          e_en);
      chk({ph, ".lights_out"},  lights_out,  e_lo);
      chk({ph, ".react_valid"}, react_valid, e_rv);
      chk({ph, ".busy"},        busy,        e_busy);
   endtask

   // called at the first ABORT cycle; n lamps lit, prev = en issued last cycle
   task automatic abort_phase(input int n, input bit prev);
      int m;
      int first;
      int x;
      m     = (n == 0) ? 0 : 9 - n;
      first = prev ? 1 : 0;
      x     = (m == 0) ? 0 : first + 2 * (m - 1) + 2;
      for (int i = 0; i <= x; i++) begin
         bit e;
         e = (m != 0) && (i >= first) && (((i - first) % 2) == 0) && (((i - first) / 2) < m);
         outs("abort", e, 1'b0, 1'b0, 1'b1);
         chk("abort.jump", jump_start, 1);
         next_cyc();
      end
      outs("abort_exit", 1'b0, 1'b0, 1'b0, 1'b0);
      chk("abort_exit.lights", lights, 8'h00);
      chk("abort_exit.jump", jump_start, 1);
      chk("abort_exit.rt", react_time, last_rt);
   endtask

   // jmode: 0 normal + reaction rk, 1 jump in HOLD at jarg, 2 jump in STEP at jarg, 3 reset in HOLD at jarg
   task automatic run_seq(input int jmode, input int jarg, input int rk, input bit noise);
      int gap;
      int L;
      int H;
      int j;
      gap     = $urandom_range(1, 6);
      trigger = 1'b0;
      btn     = 1'b0;
      L       = 0;
      for (int g = 0; g < gap; g++) begin
         outs("idle", 1'b0, 1'b0, 1'b0, 1'b0);
         next_cyc();
      end
      outs("trig", 1'b0, 1'b0, 1'b0, 1'b0);
      trigger = 1'b1;
      next_cyc();
      trigger = 1'b0;
      chk("trig.jump_clr", jump_start, 0);
      for (int c = 1; c <= 8 * T; c++) begin
         outs("step", (c % T) == 0, 1'b0, 1'b0, 1'b1);
         if (c == 8 * T) L = seq[n_rst % 127];
         trigger = noise ? 1'($urandom % 2) : 1'b0;
         if (jmode == 2 && c == jarg) begin
            btn = 1'b1;
            next_cyc();
            btn     = 1'b0;
            trigger = 1'b0;
            abort_phase(c / T, (c % T) == 0);
            return;
         end
         next_cyc();
      end
      H = T + 8 * L;
      j = (jarg < H) ? jarg : 1 + (jarg % (H - 1));
      for (int c = 1; c < H; c++) begin
         outs("hold", 1'b0, 1'b0, 1'b0, 1'b1);
         if (c == 1) chk("hold.lights_ff", lights, 8'hFF);
         if (jmode == 3 && c == j) begin
            rst     = 1'b1;
            trigger = 1'b0;
            next_cyc();
            rst = 1'b0;
            outs("rst", 1'b0, 1'b0, 1'b0, 1'b0);
            chk("rst.lights", lights, 8'h00);
            chk("rst.jump", jump_start, 0);
            chk("rst.rt", react_time, 0);
            last_rt = 16'd0;
            return;
         end
         if (jmode == 1 && c == j) begin
            btn     = 1'b1;
            trigger = 1'b0;
            next_cyc();
            btn = 1'b0;
            abort_phase(8, 1'b0);
            return;
         end
         trigger = noise ? 1'($urandom % 2) : 1'b0;
         next_cyc();
      end
      outs("lights_out", 1'b1, 1'b1, 1'b0, 1'b1);
      trigger = noise ? 1'($urandom % 2) : 1'b0;
      next_cyc();
      chk("post_lo.lights", lights, 8'h00);
      for (int k = 1; k < rk; k++) begin
         outs("react", 1'b0, 1'b0, 1'b0, 1'b1);
         chk("react.rt_hold", react_time, last_rt);
         trigger = noise ? 1'($urandom % 2) : 1'b0;
         next_cyc();
      end
      outs("react_btn", 1'b0, 1'b0, 1'b0, 1'b1);
      btn     = 1'b1;
      trigger = 1'b0;
      next_cyc();
      btn = 1'b0;
      outs("valid", 1'b0, 1'b0, 1'b1, 1'b0);
      chk("valid.react_time", react_time, rk);
      chk("valid.jump", jump_start, 0);
      last_rt = 16'(rk);
      next_cyc();
      outs("after", 1'b0, 1'b0, 1'b0, 1'b0);
      chk("after.rt_hold", react_time, rk);
   endtask

   initial begin
      logic [6:0] v;
      v = 7'h01;
      for (int i = 0; i < 127; i++) begin
         seq[i] = v;
         v = {v[5:0], v[6] ^ v[5]};
      end
      rst     = 1'b1;
      trigger = 1'b0;
      btn     = 1'b0;
      last_rt = 16'd0;
      repeat (3) next_cyc();
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
         chk("reset.jump", jump_start, 0);
         chk("reset.rt", react_time, 0);
         next_cyc();
      end

      run_seq(0, 0, 37, 1'b0);
      run_seq(1, 3, 0, 1'b0);
      run_seq(0, 0, $urandom_range(1, 60), 1'b1);
      run_seq(2, 13, 0, 1'b0);
      run_seq(2, $urandom_range(1, 8 * T), 0, 1'b1);
      run_seq(3, $urandom_range(1, 200), 0, 1'b0);
      run_seq(0, 0, $urandom_range(1, 60), 1'b1);
      for (int r = 0; r < 4; r++) begin
         case ($urandom_range(0, 3))
            0:       run_seq(0, 0, $urandom_range(1, 80), 1'b1);
            1:       run_seq(1, $urandom_range(1, 300), 0, 1'b1);
            2:       run_seq(2, $urandom_range(1, 8 * T), 0, 1'b1);
            default: run_seq(3, $urandom_range(1, 300), 0, 1'b1);
         endcase
      end
      run_seq(0, 0, 1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
